// File: rtl/multdiv_issue.sv
// ---------------------------------------------------------------------------
// multdiv_issue
//
// Issue/writeback controller that sits directly upstream of the
// non-restoring divider and the multiplier. It takes one request from the
// execute stage, latches the operands and the destination register, pulses
// the selected unit's start control, stalls the pipeline until that unit
// reports ready, and then presents a one-cycle writeback.
//
// It also handles:
//   - the stale-high ready that both units show while idle,
//   - divide-by-zero,
//   - flush, by draining the busy unit,
//   - a watchdog timeout for a unit that never answers.
//
// Optional build macro:
//   MULTDIV_EARLY_WB_EN - when defined, a completion seen in WAIT is written
//                         back combinationally in the same cycle, skipping
//                         DONE. Divide-by-zero and timeout still go through
//                         DONE.
//
// Ports:
//   clock, reset              clock; asynchronous active-low reset
//   issue_valid/is_div/a/b/rd request from the execute stage
//   flush                     cancels the in-flight request
//   unit_operandA/B           latched operands, shared by both units
//   ctrl_DIV / ctrl_MULT      one-cycle start pulses
//   div_* / mult_*            unit results, exceptions and ready flags
//   stall                     holds the upstream pipeline
//   wb_valid/rd/data/exception  writeback; values hold between strobes
// ---------------------------------------------------------------------------
module multdiv_issue #(
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic            issue_is_div,
    input  logic [31:0]     issue_a,
    input  logic [31:0]     issue_b,
    input  logic [RD_W-1:0] issue_rd,
    input  logic            flush,
    output logic [31:0]     unit_operandA,
    output logic [31:0]     unit_operandB,
    output logic            ctrl_DIV,
    output logic            ctrl_MULT,
    input  logic [31:0]     div_result,
    input  logic            div_exception,
    input  logic            div_resultRDY,
    input  logic [31:0]     mult_result,
    input  logic            mult_exception,
    input  logic            mult_resultRDY,
    output logic            stall,
    output logic            wb_valid,
    output logic [RD_W-1:0] wb_rd,
    output logic [31:0]     wb_data,
    output logic            wb_exception
);

    localparam int DATA_W = 32;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

`ifdef MULTDIV_EARLY_WB_EN
    localparam bit EARLY_WB_EN = 1'b1;
`else
    localparam bit EARLY_WB_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ARM,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t                    state;

    // Request latched at issue
    logic [DATA_W-1:0]         op_a_p0;
    logic [DATA_W-1:0]         op_b_p0;
    logic [RD_W-1:0]           rd_p0;
    logic                      is_div_p0;

    // Completion captured from the unit (or forced by div-by-zero / timeout)
    logic signed [DATA_W-1:0]  res_p1;
    logic                      exc_p1;
    logic [CNT_W-1:0]          wait_cnt;

    // Last writeback actually presented; drives wb_* between strobes
    logic [RD_W-1:0]           wb_rd_p2;
    logic [DATA_W-1:0]         wb_data_p2;
    logic                      wb_exc_p2;

    logic                      ctrl_div_q;
    logic                      ctrl_mult_q;

    logic                      sel_rdy;
    logic [DATA_W-1:0]         sel_res;
    logic                      sel_exc;
    logic                      early_wb;

    // The latched is_div selects which unit's handshake we are following.
    always_comb begin
        sel_rdy = is_div_p0 ? div_resultRDY  : mult_resultRDY;
        sel_res = is_div_p0 ? div_result     : mult_result;
        sel_exc = is_div_p0 ? div_exception  : mult_exception;
    end

    assign early_wb = EARLY_WB_EN && (state == S_WAIT) && sel_rdy && !flush;

    assign unit_operandA = op_a_p0;
    assign unit_operandB = op_b_p0;
    assign ctrl_DIV      = ctrl_div_q;
    assign ctrl_MULT     = ctrl_mult_q;

    always_comb begin
        case (state)
            S_START, S_ARM, S_DRAIN: stall = 1'b1;
            S_WAIT:                  stall = !early_wb;
            default:                 stall = 1'b0;
        endcase
    end

    // Writeback mux. A flush during DONE suppresses the strobe and leaves
    // the held values untouched, so wb_* only ever change on a real strobe.
    always_comb begin
        wb_valid     = 1'b0;
        wb_rd        = wb_rd_p2;
        wb_data      = wb_data_p2;
        wb_exception = wb_exc_p2;
        if (early_wb) begin
            wb_valid     = 1'b1;
            wb_rd        = rd_p0;
            wb_data      = sel_res;
            wb_exception = sel_exc;
        end else if ((state == S_DONE) && !flush) begin
            wb_valid     = 1'b1;
            wb_rd        = rd_p0;
            wb_data      = res_p1;
            wb_exception = exc_p1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            op_a_p0     <= '0;
            op_b_p0     <= '0;
            rd_p0       <= '0;
            is_div_p0   <= 1'b0;
            res_p1      <= '0;
            exc_p1      <= 1'b0;
            wait_cnt    <= '0;
            wb_rd_p2    <= '0;
            wb_data_p2  <= '0;
            wb_exc_p2   <= 1'b0;
            ctrl_div_q  <= 1'b0;
            ctrl_mult_q <= 1'b0;
        end else begin
            // Start pulses are single-cycle by construction.
            ctrl_div_q  <= 1'b0;
            ctrl_mult_q <= 1'b0;

            // ---- stage boundary: writeback hold registers ----
            if (wb_valid) begin
                wb_rd_p2   <= wb_rd;
                wb_data_p2 <= wb_data;
                wb_exc_p2  <= wb_exception;
            end

            case (state)
                // ---- stage boundary: request accept ----
                S_IDLE: begin
                    if (issue_valid && !flush) begin
                        op_a_p0     <= issue_a;
                        op_b_p0     <= issue_b;
                        rd_p0       <= issue_rd;
                        is_div_p0   <= issue_is_div;
                        ctrl_div_q  <= issue_is_div;
                        ctrl_mult_q <= !issue_is_div;
                        state       <= S_START;
                    end
                end

                // The start pulse is visible this cycle; once it has gone out
                // the unit is committed, so a flush has to drain it.
                S_START: begin
                    state <= flush ? S_DRAIN : S_ARM;
                end

                // Ready is still stale-high from idle here, so it is not
                // looked at until WAIT.
                S_ARM: begin
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if (is_div_p0 && (op_b_p0 == '0)) begin
                        res_p1 <= '0;
                        exc_p1 <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_WAIT;
                    end
                end

                // ---- stage boundary: unit completion capture ----
                S_WAIT: begin
                    if (flush) begin
                        state <= S_DRAIN;
                    end else if (sel_rdy) begin
                        res_p1 <= sel_res;
                        exc_p1 <= sel_exc;
                        state  <= early_wb ? S_IDLE : S_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // Unit assumed hung: complete with an exception and
                        // do not wait for it to drain.
                        res_p1 <= '0;
                        exc_p1 <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                // The unit cannot be aborted and ignores a start while busy,
                // so stay stalled until it is idle again.
                S_DRAIN: begin
                    if (sel_rdy) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_issue.sv
module tb_multdiv_issue;

    localparam int RD_W    = 5;
    localparam int TIMEOUT = 64;
    localparam int DIV_LAT = 33;
    localparam int MUL_LAT = 8;
`ifdef MULTDIV_EARLY_WB_EN
    localparam int E = 1;
`else
    localparam int E = 0;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            issue_valid = 1'b0;
    logic            issue_is_div = 1'b0;
    logic [31:0]     issue_a = '0;
    logic [31:0]     issue_b = '0;
    logic [RD_W-1:0] issue_rd = '0;
    logic            flush = 1'b0;
    logic [31:0]     unit_operandA, unit_operandB;
    logic            ctrl_DIV, ctrl_MULT;
    logic [31:0]     div_result, mult_result;
    logic            div_exception, mult_exception;
    logic            div_resultRDY, mult_resultRDY;
    logic            stall, wb_valid, wb_exception;
    logic [RD_W-1:0] wb_rd;
    logic [31:0]     wb_data;

    multdiv_issue #(.RD_W(RD_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .issue_valid(issue_valid), .issue_is_div(issue_is_div),
        .issue_a(issue_a), .issue_b(issue_b), .issue_rd(issue_rd),
        .flush(flush),
        .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
        .ctrl_DIV(ctrl_DIV), .ctrl_MULT(ctrl_MULT),
        .div_result(div_result), .div_exception(div_exception),
        .div_resultRDY(div_resultRDY),
        .mult_result(mult_result), .mult_exception(mult_exception),
        .mult_resultRDY(mult_resultRDY),
        .stall(stall), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Divider model: busy DIV_LAT cycles after an accepted start, ready high while idle.
    int          dcnt;
    logic [31:0] dres;
    logic        dexc;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            dcnt <= 0; dres <= '0; dexc <= 1'b0;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
        end else if (ctrl_DIV) begin
            dcnt <= DIV_LAT;
            if (unit_operandB == 0) begin
                dres <= '0; dexc <= 1'b1;
            end else begin
                dres <= $signed(unit_operandA) / $signed(unit_operandB);
                dexc <= 1'b0;
            end
        end
    end
    assign div_resultRDY = (dcnt == 0);
    assign div_result    = dres;
    assign div_exception = dexc;

    // Multiplier model; with mult_hang set, a start leaves it busy until reset.
    logic        mult_hang = 1'b0;
    int          mcnt;
    logic        mhung;
    logic [31:0] mres;
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mcnt <= 0; mhung <= 1'b0; mres <= '0;
        end else if (mcnt != 0) begin
            mcnt <= mcnt - 1;
        end else if (ctrl_MULT && !mhung) begin
            if (mult_hang) mhung <= 1'b1;
            else begin
                mcnt <= MUL_LAT;
                mres <= $signed(unit_operandA) * $signed(unit_operandB);
            end
        end
    end
    assign mult_resultRDY = (mcnt == 0) && !mhung;
    assign mult_result    = mres;
    assign mult_exception = 1'b0;

    typedef struct {
        logic [RD_W-1:0] rd;
        logic [31:0]     data;
        logic            exc;
        int              at;
    } exp_t;
    exp_t sb[$];

    always @(negedge clock) begin
        exp_t e;
        if (wb_valid) begin
            if (sb.size() == 0) begin
                check("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("wb_cycle", cyc, e.at);
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
                check("wb_data", wb_data, e.data);
                check("wb_exc", 32'(wb_exception), 32'(e.exc));
            end
        end
    end

    int t0 = 0;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input bit d, input logic [31:0] a, input logic [31:0] b,
                         input logic [RD_W-1:0] rd, input bit fl, input bit push,
                         input logic [31:0] ed, input bit ee, input int lat);
        issue_valid  = 1'b1;
        issue_is_div = d;
        issue_a      = a;
        issue_b      = b;
        issue_rd     = rd;
        flush        = fl;
        t0           = cyc;
        if (push) sb.push_back('{rd, ed, ee, t0 + lat});
        tick();
        issue_valid = 1'b0;
        flush       = 1'b0;
        if (!fl) begin
            check("op_a", unit_operandA, a);
            check("op_b", unit_operandB, b);
        end
    endtask

    // Follows cycles t0+1 .. t0+n: stall must be high exactly for r<=stall_hi,
    // and the selected start pulse must appear once at r==1 (if expected).
    task automatic watch(input int n, input bit d, input bit pulse,
                         input int stall_hi, input int flush_at);
        int bad = 0;
        int pd = 0;
        int pm = 0;
        int first = -1;
        for (int r = 1; r <= n; r++) begin
            flush = (r == flush_at);
            @(negedge clock);
            if (stall !== (r <= stall_hi)) bad++;
            if (ctrl_DIV)  begin pd++; if (first < 0) first = r; end
            if (ctrl_MULT) begin pm++; if (first < 0) first = r; end
            tick();
        end
        flush = 1'b0;
        check("stall_window", bad, 0);
        check("div_pulses", pd, (pulse && d) ? 1 : 0);
        check("mult_pulses", pm, (pulse && !d) ? 1 : 0);
        if (pulse) check("pulse_cycle", first, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_wbv"}, 32'(wb_valid), 32'd0);
        check({tag, "_ctrl"}, 32'({ctrl_DIV, ctrl_MULT}), 32'd0);
        check({tag, "_opa"}, unit_operandA, 32'd0);
        check({tag, "_opb"}, unit_operandB, 32'd0);
        check({tag, "_wbrd"}, 32'(wb_rd), 32'd0);
        check({tag, "_wbdata"}, wb_data, 32'd0);
        check({tag, "_wbexc"}, 32'(wb_exception), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_zero_outputs("reset");
        @(posedge clock); #1;
        reset = 1'b1;
        tick();

        // Divide 100/7 -> 14
        issue(1, 32'd100, 32'd7, 5'd3, 0, 1, 32'd14, 0, 36 - E);
        watch(36, 1, 1, 35 - E, 0);

        // Divide -100/7 -> -14
        issue(1, -32'sd100, 32'd7, 5'd4, 0, 1, 32'hFFFF_FFF2, 0, 36 - E);
        watch(36, 1, 1, 35 - E, 0);

        // Divide-by-zero completes through DONE at t0+3
        issue(1, 32'd5, 32'd0, 5'd7, 0, 1, 32'd0, 1, 3);
        watch(3, 1, 1, 2, 0);
        repeat (40) tick();
        check("hold_rd", 32'(wb_rd), 32'd7);
        check("hold_data", wb_data, 32'd0);
        check("hold_exc", 32'(wb_exception), 32'd1);

        // Divide-by-zero flushed during DONE: no strobe, held values unchanged
        issue(1, 32'd8, 32'd0, 5'd8, 0, 0, 32'd0, 0, 0);
        watch(3, 1, 1, 2, 3);
        repeat (40) tick();
        check("flushed_done_rd", 32'(wb_rd), 32'd7);

        // Flush in WAIT: drain until divider ready (t0+35), IDLE at t0+36
        issue(1, 32'd100, 32'd7, 5'd10, 0, 0, 32'd0, 0, 0);
        watch(35, 1, 1, 35, 10);
        check("idle_after_drain", 32'(stall), 32'd0);
        issue(1, 32'd9, 32'd3, 5'd9, 0, 1, 32'd3, 0, 36 - E);
        watch(36, 1, 1, 35 - E, 0);

        // Flush in the same cycle as issue drops the request
        issue(1, 32'd50, 32'd5, 5'd11, 1, 0, 32'd0, 0, 0);
        watch(3, 1, 0, 0, 0);
        check("drop_op_a", unit_operandA, 32'd9);

        // Multiplies
        issue(0, 32'd6, 32'd7, 5'd2, 0, 1, 32'd42, 0, MUL_LAT + 3 - E);
        watch(MUL_LAT + 3, 0, 1, MUL_LAT + 2 - E, 0);
        issue(0, -32'sd3, 32'd5, 5'd12, 0, 1, 32'hFFFF_FFF1, 0, MUL_LAT + 3 - E);
        watch(MUL_LAT + 3, 0, 1, MUL_LAT + 2 - E, 0);

        // Hung multiplier: timeout exception at t0+TIMEOUT+3
        mult_hang = 1'b1;
        issue(0, 32'd3, 32'd4, 5'd5, 0, 1, 32'd0, 1, TIMEOUT + 3);
        watch(TIMEOUT + 3, 0, 1, TIMEOUT + 2, 0);

        // Reset in the middle of WAIT
        issue(0, 32'd2, 32'd2, 5'd6, 0, 0, 32'd0, 0, 0);
        watch(10, 0, 1, 10, 0);
        reset = 1'b0;
        @(negedge clock);
        check_zero_outputs("midreset");
        mult_hang = 1'b0;
        tick();
        reset = 1'b1;
        issue(0, -32'sd3, 32'd5, 5'd1, 0, 1, 32'hFFFF_FFF1, 0, MUL_LAT + 3 - E);
        watch(MUL_LAT + 3, 0, 1, MUL_LAT + 2 - E, 0);

        repeat (5) tick();
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
